pwadc_sequencer_avg: RTL

- Control and result stage wrapped around the pulse-width conversion ADC.
- Issues the one-cycle `start_conversion` pulse that kicks the ADC.
- Times the fixed conversion window, captures the ADC's 8-bit `digital_output`, and averages 2^AVG_LOG2 consecutive results.
- Presents the rounded average downstream on a valid/ready handshake, with a sticky overrun flag.

---
 rtl/pwadc_sequencer_avg.sv | 135 +++++++++++++
 1 files changed

// File: rtl/pwadc_sequencer_avg.sv
// Sequencer for the pulse-width ADC: pulses start, times the conversion window,
// captures each result and presents a rounded 2^AVG_LOG2-sample average on valid/ready.
module pwadc_sequencer_avg #(
    parameter int WIDTH       = 8,
    parameter int AVG_LOG2    = 2,
    parameter int CONV_CYCLES = 770
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    output logic             start_conversion,
    input  logic [WIDTH-1:0] adc_result,
    output logic [WIDTH-1:0] avg_data,
    output logic             avg_valid,
    input  logic             avg_ready,
    output logic             overrun,
    input  logic             overrun_clr,
    output logic             busy
);

    localparam int N     = 1 << AVG_LOG2;
    localparam int ACC_W = WIDTH + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int TMR_W = $clog2(CONV_CYCLES);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(N - 1);
    localparam logic [TMR_W-1:0] TMR_LOAD   = TMR_W'(CONV_CYCLES - 2);
    localparam logic [ACC_W-1:0] ROUND_HALF = ACC_W'(N / 2);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_START   = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_CAPTURE = 2'd3;

    // Round-half-up divide by N; the biased sum never exceeds ACC_W bits.
    function automatic logic [WIDTH-1:0] round_avg(input logic [ACC_W-1:0] sum);
        logic [ACC_W-1:0] biased;
        biased = sum + ROUND_HALF;
        return biased[ACC_W-1:AVG_LOG2];
    endfunction

    logic [1:0]       state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic [ACC_W-1:0] sum;
    logic             load;
    logic             accept;

    assign sum    = acc_q + ACC_W'(adc_result);
    assign accept = valid_q & avg_ready;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                acc_d = '0;
                cnt_d = '0;
                if (enable) state_d = S_START;
            end
            S_START: begin
                timer_d = TMR_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (timer_q == '0) state_d = S_CAPTURE;
                else               timer_d = timer_q - TMR_W'(1);
            end
            S_CAPTURE: begin
                if (cnt_q == CNT_LAST) begin
                    load   = 1'b1;
                    data_d = round_avg(sum);
                    acc_d  = '0;
                    cnt_d  = '0;
                end else begin
                    acc_d = sum;
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // A partial average is dropped when the run stops.
                if (enable) begin
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (load)        valid_d = 1'b1;
        else if (accept) valid_d = 1'b0;
        if (load && valid_q && !accept) ovr_d = 1'b1;
        else if (overrun_clr)           ovr_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign start_conversion = (state_q == S_START);
    assign busy             = (state_q != S_IDLE);
    assign avg_data         = data_q;
    assign avg_valid        = valid_q;
    assign overrun          = ovr_q;

endmodule
